// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: segment-pattern constants, reader FSM states and the shared segment decoder.
// Segment patterns are {a,b,c,d,e,f,g} with bit 6 = a, active-high.
// SEVENSEG_READER_HEX_EN: when defined, seg_decode also accepts the A..F glyphs.
package sevenseg_pkg;
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1110011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} rdr_state_t;

    // Returns {ok, value}; an unrecognised pattern yields {0, 4'hF}.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            SEG_0: return 5'h10;
            SEG_1: return 5'h11;
            SEG_2: return 5'h12;
            SEG_3: return 5'h13;
            SEG_4: return 5'h14;
            SEG_5: return 5'h15;
            SEG_6: return 5'h16;
            SEG_7: return 5'h17;
            SEG_8: return 5'h18;
            SEG_9: return 5'h19;
`ifdef SEVENSEG_READER_HEX_EN
            SEG_A: return 5'h1A;
            SEG_B: return 5'h1B;
            SEG_C: return 5'h1C;
            SEG_D: return 5'h1D;
            SEG_E: return 5'h1E;
            SEG_F: return 5'h1F;
`endif
            default: return 5'h0F;
        endcase
    endfunction
endpackage

// File: rtl/sevenseg_evt_buf.sv
// sevenseg_evt_buf: one-entry valid/ready event register with sticky overflow.
// Ports: clk, reset (async, active-high); i_push/i_idx/i_value/i_err load a new event;
// i_ready consumes; o_valid/o_idx/o_value/o_err hold the pending event; o_overflow is sticky.
module sevenseg_evt_buf (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [2:0] i_idx,
    input  logic [3:0] i_value,
    input  logic       i_err,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [2:0] o_idx,
    output logic [3:0] o_value,
    output logic       o_err,
    output logic       o_overflow
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid    <= 1'b0;
            o_idx      <= '0;
            o_value    <= '0;
            o_err      <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_push && (!o_valid || i_ready)) begin
            o_valid <= 1'b1;
            o_idx   <= i_idx;
            o_value <= i_value;
            o_err   <= i_err;
        end else begin
            // A push reaching here found the slot full and unconsumed: drop it.
            if (i_ready) o_valid <= 1'b0;
            if (i_push) o_overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/sevenseg_reader.sv
// sevenseg_reader: recovers per-position digit values from a multiplexed seven-segment bus.
// Ports: clk, reset (async, active-high); dig_sel (one-hot select), seg_in {a..g};
// digits/digit_ok per position; evt_valid/evt_ready/evt_idx/evt_value/evt_err event port;
// overflow sticky on a dropped event. Optional macro SEVENSEG_READER_HEX_EN adds A..F glyphs.
module sevenseg_reader
    import sevenseg_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NDIG-1:0]   dig_sel,
    input  logic [6:0]        seg_in,
    output logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   digit_ok,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [2:0]        evt_idx,
    output logic [3:0]        evt_value,
    output logic              evt_err,
    output logic              overflow
);
    rdr_state_t      r_state;
    logic [NDIG-1:0] r_sel;
    logic [6:0]      r_seg;
    logic [7:0]      r_cnt;
    logic            w_onehot, w_new, w_cap, w_ok, w_upd, w_push, w_dok;
    logic [7:0]      w_cnt_nxt;
    logic [4:0]      w_dec;
    logic [3:0]      w_val, w_cur;
    logic [2:0]      w_idx;

    assign w_onehot  = $onehot(dig_sel);
    assign w_new     = w_onehot && (r_state == IDLE || dig_sel != r_sel || seg_in != r_seg);
    assign w_cnt_nxt = w_new ? 8'd1 : (&r_cnt ? r_cnt : r_cnt + 8'd1);
    // Capture on the edge where the count reaches STABLE; a stable pair in HOLD never recaptures.
    assign w_cap     = w_onehot && (r_state != HOLD || w_new) && w_cnt_nxt == 8'(STABLE);
    assign w_dec     = seg_decode(seg_in);
    assign w_ok      = w_dec[4];
    assign w_val     = w_dec[3:0];
    assign w_upd     = w_cap && w_ok && (!w_dok || w_cur != w_val);
    assign w_push    = w_cap && (!w_ok || w_upd);

    always_comb begin
        w_idx = '0;
        w_cur = '0;
        w_dok = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_sel[i]) begin
                w_idx = 3'(i);
                w_cur = digits[4*i +: 4];
                w_dok = digit_ok[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_seg    <= '0;
            r_cnt    <= '0;
            digits   <= '0;
            digit_ok <= '0;
        end else begin
            r_state <= !w_onehot ? IDLE : w_cap ? HOLD : w_new ? SETTLE : r_state;
            if (w_onehot) begin
                r_sel <= dig_sel;
                r_seg <= seg_in;
                r_cnt <= w_cnt_nxt;
            end
            for (int i = 0; i < NDIG; i++) begin
                if (w_upd && dig_sel[i]) begin
                    digits[4*i +: 4] <= w_val;
                    digit_ok[i]      <= 1'b1;
                end
            end
        end
    end

    sevenseg_evt_buf u_evt (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_idx      (w_idx),
        .i_value    (w_val),
        .i_err      (!w_ok),
        .i_ready    (evt_ready),
        .o_valid    (evt_valid),
        .o_idx      (evt_idx),
        .o_value    (evt_value),
        .o_err      (evt_err),
        .o_overflow (overflow)
    );
endmodule

// File: tb/tb_sevenseg_reader.sv
// tb_sevenseg_reader: table-driven, scoreboarded self-check of sevenseg_reader (NDIG=4, STABLE=3).
module tb_sevenseg_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  dig_sel = '0;
    logic [6:0]  seg_in = '0;
    logic        evt_ready = 1'b1;
    logic [15:0] digits;
    logic [3:0]  digit_ok;
    logic        evt_valid, evt_err, overflow;
    logic [2:0]  evt_idx;
    logic [3:0]  evt_value;

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        int         n;
        bit         ev;
        logic [2:0] idx;
        logic [3:0] val;
        bit         err;
        logic [3:0] ok;
    } vec_t;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] val;
        bit         err;
    } ev_t;

    vec_t tab[$];
    ev_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [6:0] segs [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

    sevenseg_reader #(.NDIG(4), .STABLE(3)) dut (
        .clk(clk), .reset(reset), .dig_sel(dig_sel), .seg_in(seg_in),
        .digits(digits), .digit_ok(digit_ok), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_idx(evt_idx), .evt_value(evt_value), .evt_err(evt_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic vec_t mk(input logic [3:0] sel, input logic [6:0] seg, input int n,
                                input bit ev, input logic [2:0] idx, input logic [3:0] val,
                                input bit err, input logic [3:0] ok);
        vec_t v;
        v.sel = sel; v.seg = seg; v.n = n; v.ev = ev;
        v.idx = idx; v.val = val; v.err = err; v.ok = ok;
        return v;
    endfunction

    task automatic run_row(input vec_t v);
        dig_sel = v.sel;
        seg_in  = v.seg;
        if (v.ev) sb.push_back('{v.idx, v.val, v.err});
        cyc(v.n);
        chk("digit_ok", 32'(digit_ok), 32'(v.ok));
    endtask

    task automatic check_reset_state();
        chk("rst_digits", 32'(digits), 0);
        chk("rst_digit_ok", 32'(digit_ok), 0);
        chk("rst_evt_valid", 32'(evt_valid), 0);
        chk("rst_evt_idx", 32'(evt_idx), 0);
        chk("rst_evt_value", 32'(evt_value), 0);
        chk("rst_evt_err", 32'(evt_err), 0);
        chk("rst_overflow", 32'(overflow), 0);
    endtask

    // Every handshake seen here is consumed at the next rising edge.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_evt: got idx %0d val %0h err %0d want none",
                         evt_idx, evt_value, evt_err);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("evt_idx", 32'(evt_idx), 32'(e.idx));
                chk("evt_value", 32'(evt_value), 32'(e.val));
                chk("evt_err", 32'(evt_err), 32'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] ok_hex;
        for (int d = 0; d < 10; d++) tab.push_back(mk(4'b0100, segs[d], 3, 1, 2, 4'(d), 0, 4'b0100));
        tab.push_back(mk(4'b0000, 7'b0, 2, 0, 0, 0, 0, 4'b0100));
        tab.push_back(mk(4'b0001, 7'b1111001, 2, 0, 0, 0, 0, 4'b0100));
        tab.push_back(mk(4'b0001, 7'b0110000, 3, 1, 0, 4'h1, 0, 4'b0101));
        tab.push_back(mk(4'b0000, 7'b0, 2, 0, 0, 0, 0, 4'b0101));
        tab.push_back(mk(4'b0001, 7'b1110000, 3, 1, 0, 4'h7, 0, 4'b0101));
        tab.push_back(mk(4'b0000, 7'b0, 2, 0, 0, 0, 0, 4'b0101));
        tab.push_back(mk(4'b0001, 7'b1110000, 3, 0, 0, 0, 0, 4'b0101));
        tab.push_back(mk(4'b0001, 7'b1111111, 3, 1, 0, 4'h8, 0, 4'b0101));
        tab.push_back(mk(4'b0010, 7'b0000001, 3, 1, 1, 4'hF, 1, 4'b0101));
`ifdef SEVENSEG_READER_HEX_EN
        tab.push_back(mk(4'b0010, 7'b1110111, 3, 1, 1, 4'hA, 0, 4'b0111));
        ok_hex = 4'b0111;
`else
        tab.push_back(mk(4'b0010, 7'b1110111, 3, 1, 1, 4'hF, 1, 4'b0101));
        ok_hex = 4'b0101;
`endif
        tab.push_back(mk(4'b0000, 7'b0, 3, 0, 0, 0, 0, ok_hex));

        cyc(2);
        check_reset_state();
        reset = 1'b0;
        cyc(1);
        for (int i = 0; i < tab.size(); i++) run_row(tab[i]);
        chk("sb_drained_table", 32'(sb.size()), 0);
`ifdef SEVENSEG_READER_HEX_EN
        chk("digits_table", 32'(digits), 32'h09A8);
`else
        chk("digits_table", 32'(digits), 32'h0908);
`endif
        chk("overflow_table", 32'(overflow), 0);

        // Backpressure: second event dropped, first kept.
        evt_ready = 1'b0;
        run_row(mk(4'b0001, 7'b1101101, 3, 0, 0, 0, 0, ok_hex));
        chk("bp_valid1", 32'(evt_valid), 1);
        chk("bp_idx1", 32'(evt_idx), 0);
        chk("bp_val1", 32'(evt_value), 2);
        run_row(mk(4'b1000, 7'b1011011, 3, 0, 0, 0, 0, ok_hex | 4'b1000));
        chk("bp_overflow", 32'(overflow), 1);
        chk("bp_valid2", 32'(evt_valid), 1);
        chk("bp_idx2", 32'(evt_idx), 0);
        chk("bp_val2", 32'(evt_value), 2);
        chk("bp_err2", 32'(evt_err), 0);
        chk("bp_digit3", 32'(digits[15:12]), 5);
        dig_sel = '0;
        sb.push_back('{3'd0, 4'h2, 1'b0});
        evt_ready = 1'b1;
        cyc(1);
        chk("bp_drained_valid", 32'(evt_valid), 0);
        chk("bp_sb_empty", 32'(sb.size()), 0);

        // Reset after 2 of 3 stable cycles, pair kept on the bus across reset.
        dig_sel = 4'b0100;
        seg_in  = 7'b1111001;
        cyc(2);
        reset = 1'b1;
        #1;
        check_reset_state();
        cyc(1);
        reset = 1'b0;
        cyc(1);
        chk("post_rst_valid1", 32'(evt_valid), 0);
        cyc(1);
        chk("post_rst_valid2", 32'(evt_valid), 0);
        sb.push_back('{3'd2, 4'h3, 1'b0});
        cyc(1);
        chk("post_rst_valid3", 32'(evt_valid), 1);
        chk("post_rst_digits", 32'(digits), 32'h0300);
        dig_sel = '0;
        cyc(3);
        chk("sb_drained_final", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sevenseg_reader.md
# sevenseg_reader

Observes a multiplexed seven-segment display bus, with one-hot digit select and a shared segment pattern, and recovers the digit value shown on each position. It is the decode side of the `sevenseg` encoder: it maps 7-bit segment patterns back to 4-bit values. Each pattern must be stable for a programmable number of cycles before it is accepted. Accepted changes are reported through a one-deep valid/ready event port. The block sits between a display-bus tap, such as a scoreboard or self-check harness, and any logic that consumes displayed values.

## Interface
- `NDIG`, 4: number of multiplexed digit positions (1..8).
- `STABLE`, 3: consecutive cycles a (select, pattern) pair must hold before capture (1..255).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `dig_sel` in NDIG: one-hot digit select, active-high; zero or multi-hot means the bus is idle.
- `seg_in` in 7: segment pattern `{a,b,c,d,e,f,g}`, bit 6 = a, active-high.
- `digits` out 4*NDIG: last accepted value per position; position i occupies bits [4i+3:4i].
- `digit_ok` out NDIG: position has accepted a valid pattern since reset.
- `evt_valid` out 1: event pending.
- `evt_ready` in 1: consumer accepts the event.
- `evt_idx` out 3: position of the event.
- `evt_value` out 4: decoded value of the event.
- `evt_err` out 1: event reports an undecodable pattern; `evt_value` = 4'hF.
- `overflow` out 1: sticky; set when an event is dropped. Cleared only by reset.

## Operation
- **Decode table:**
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - 8 = 1111111
  - 9 = 1110011
  - Any other pattern is invalid.
- **FSM states:** IDLE, SETTLE, HOLD.
  - IDLE: `dig_sel` is not one-hot. When `dig_sel` becomes one-hot, latch the (sel, seg) pair, load the counter with 1, and go to SETTLE.
  - SETTLE: if the pair equals the latched pair, increment the counter. When the counter reaches `STABLE`, capture and go to HOLD.
  - SETTLE, pair changed to another one-hot pair: relatch it, counter = 1, stay in SETTLE.
  - SETTLE or HOLD, `dig_sel` not one-hot: go to IDLE.
  - HOLD: wait for a change. A changed one-hot pair relatches and moves to SETTLE.
- **Capture:**
  - Valid pattern, value differs from `digits[i]` or `digit_ok[i]` = 0: update `digits[i]`, set `digit_ok[i]`, generate an event.
  - Valid pattern equal to the stored value: no event.
  - Invalid pattern: generate an error event; `digits` and `digit_ok` are unchanged.
- **Event register:**
  - One entry; `evt_*` fields are held stable while `evt_valid` = 1.
  - The event is consumed on `evt_valid && evt_ready`.
  - A new event arriving in the same cycle as consumption is loaded; `evt_valid` stays 1.
  - A new event arriving while an event is pending and not consumed is dropped, and `overflow` is set. The pending event is kept.
- **Counter:** 8 bits, saturating. It never wraps while in HOLD.

## Timing
- Reset values: `digits` = 0, `digit_ok` = 0, `evt_valid` = 0, `evt_idx` = 0, `evt_value` = 0, `evt_err` = 0, `overflow` = 0, FSM = IDLE.
- Latency: a pair first seen at cycle N, held stable, raises `evt_valid` after the clock edge at the end of cycle N+STABLE-1. With `STABLE` = 1, `evt_valid` is visible in cycle N+1.
- `digits` updates on the same edge that raises `evt_valid`.
- Reset asserted mid-SETTLE or with an event pending discards all state immediately. No event is emitted after reset is released until a fresh full settle completes.

## Configuration
- `SEVENSEG_READER_HEX_EN` defined:
  - Additionally decodes A = 1110111, b = 0011111, C = 1001110, d = 0111101, E = 1001111, F = 1000111.
  - F is then a legitimate value; `evt_err` alone distinguishes errors.
- Not defined: those six patterns are invalid and produce error events.

## Structure
- Package `sevenseg_pkg` holds:
  - segment-pattern constants `SEG_0`..`SEG_F`;
  - the FSM state enum `rdr_state_t`;
  - function `seg_decode(seg) -> {ok, value}`, guarded internally by `SEVENSEG_READER_HEX_EN`.
- The package is shared with `sevenseg` so that encoder and decoder cannot diverge.
- One sub-module, `sevenseg_evt_buf`: the one-entry valid/ready register with overflow detection.

## Test plan
- Loopback, all ten digits: drive each `sevenseg` output for digits 0..9 on position 2, `dig_sel` = 4'b0100, each held 3 cycles, `evt_ready` = 1 -> ten events, idx = 2, values 0..9, no errors.
- Glitch rejection: hold pattern 1111001 for 2 cycles, then 0110000 for 3 cycles, `STABLE` = 3 -> exactly one event, value 1.
- Repeat suppression: hold 7 (1110000) on position 0, go idle, then show 7 again -> exactly one event. A subsequent 8 (1111111) -> second event, value 8.
- Invalid pattern: hold 0000001 for 3 cycles on position 1 -> `evt_err` = 1, `evt_value` = F, `digit_ok[1]` stays 0.
  - With `SEVENSEG_READER_HEX_EN`, pattern 1110111 -> value A, `evt_err` = 0.
- Backpressure: `evt_ready` = 0 while two distinct values settle on positions 0 and 3 -> first event held, `overflow` = 1. Assert `evt_ready` -> first event consumed, `evt_valid` drops.
- Reset mid-settle: assert reset after 2 of 3 stable cycles -> all outputs return to reset values, and no event appears in the 2 cycles after release.
